// File: rtl/id_stage_hs.sv
// RV32I/M decode stage with valid/ready input, write-back bypass, load-use stall
// and an output FIFO. Optional M extension decode enabled by defining ID_MEXT_EN.
module id_stage_hs #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [16:0]     out_ctrl,
    output logic            hazard_stall
);
`ifdef ID_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [6:0] OP_R   = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_ST  = 7'b0100011, OP_BR  = 7'b1100011, OP_JAL  = 7'b1101111,
                           OP_JALR= 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC= 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [16:0]     ctrl;
    } entry_t;

    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic        uses_rs1, uses_rs2, src1_sel, src2_sel, mem_rd, mem_wr, reg_wr;
    logic        branch, jal, jalr, mul, div, illegal;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic [31:0] imm32;
    entry_t      dec;

    assign opc = in_instr[6:0];
    assign rd  = in_instr[11:7];
    assign f3  = in_instr[14:12];
    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];
    assign f7  = in_instr[31:25];
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    always_comb begin
        uses_rs1 = 1'b0; uses_rs2 = 1'b0; src1_sel = 1'b0; src2_sel = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; reg_wr = 1'b0; wb_sel = 2'b00;
        branch = 1'b0; jal = 1'b0; jalr = 1'b0; mul = 1'b0; div = 1'b0;
        illegal = 1'b0; alu_op = ALU_ADD; imm32 = '0;
        case (opc)
            OP_R: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; reg_wr = 1'b1;
                if (f7 == 7'b0000001) begin
                    if (MEXT) begin
                        mul = ~f3[2];
                        div = f3[2];
                    end else
                        illegal = 1'b1;
                end else if (f7 == 7'b0000000 ||
                             (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    alu_op = alu_dec(f3, f7[5]);
                else
                    illegal = 1'b1;
            end
            OP_IMM: begin
                uses_rs1 = 1'b1; reg_wr = 1'b1; src2_sel = 1'b1;
                imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
                alu_op = alu_dec(f3, (f3 == 3'b101) && in_instr[30]);
                if (f3 == 3'b001 && f7 != 7'b0000000) illegal = 1'b1;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) illegal = 1'b1;
            end
            OP_LOAD: begin
                uses_rs1 = 1'b1; reg_wr = 1'b1; src2_sel = 1'b1; mem_rd = 1'b1; wb_sel = 2'b01;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illegal = 1'b1;
            end
            OP_ST: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; src2_sel = 1'b1; mem_wr = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                if (f3 >= 3'b011) illegal = 1'b1;
            end
            OP_BR: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; branch = 1'b1;
                imm32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
                alu_op = (f3[2:1] == 2'b00) ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
                if (f3 == 3'b010 || f3 == 3'b011) illegal = 1'b1;
            end
            OP_JAL: begin
                jal = 1'b1; reg_wr = 1'b1; wb_sel = 2'b10; src1_sel = 1'b1; src2_sel = 1'b1;
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                uses_rs1 = 1'b1; jalr = 1'b1; reg_wr = 1'b1; wb_sel = 2'b10; src2_sel = 1'b1;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                if (f3 != 3'b000) illegal = 1'b1;
            end
            OP_LUI: begin
                reg_wr = 1'b1; src2_sel = 1'b1;
                imm32  = {in_instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                reg_wr = 1'b1; src1_sel = 1'b1; src2_sel = 1'b1;
                imm32  = {in_instr[31:12], 12'b0};
            end
            default: illegal = 1'b1;
        endcase
    end

    // Unused source fields are zeroed so EX never sees stale register indices
    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.imm      = XLEN'($signed(imm32));
        dec.funct3   = f3;
        dec.rs1      = uses_rs1 ? rs1 : 5'd0;
        dec.rs2      = uses_rs2 ? rs2 : 5'd0;
        dec.rd       = (reg_wr && !illegal) ? rd : 5'd0;
        dec.rs1_data = !uses_rs1 ? '0 :
                       (wb_we && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : rf_rdata1;
        dec.rs2_data = !uses_rs2 ? '0 :
                       (wb_we && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rf_rdata2;
        if (illegal)
            dec.ctrl = {1'b1, 16'b0};
        else
            dec.ctrl = {1'b0, div, mul, jalr, jal, branch, wb_sel, reg_wr,
                        mem_wr, mem_rd, src2_sel, src1_sel, alu_op};
    end

    assign hazard_stall = in_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                          ((uses_rs1 && rs1 == ex_load_rd) || (uses_rs2 && rs2 == ex_load_rd));

    entry_t             mem [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, push, pop;

    assign full      = (count == CNT_W'(BUF_DEPTH));
    assign out_valid = (count != '0);
    assign in_ready  = !full && !hazard_stall && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    entry_t head;
    assign head         = out_valid ? mem[rd_ptr] : '0;
    assign out_pc       = head.pc;
    assign out_rs1_data = head.rs1_data;
    assign out_rs2_data = head.rs2_data;
    assign out_imm      = head.imm;
    assign out_rd       = head.rd;
    assign out_rs1      = head.rs1;
    assign out_rs2      = head.rs2;
    assign out_funct3   = head.funct3;
    assign out_ctrl     = head.ctrl;
endmodule

// File: doc/id_stage_hs.md
# id_stage_hs

Handshaked, buffered RV32I/M instruction decode stage between the fetch stage and EX. Accepts one instruction per cycle over valid/ready and decodes control, immediate and register operands, with write-back bypass and load-use hazard stall. Enqueues results into a parametrised output FIFO so EX backpressure does not propagate combinationally to fetch. Flags illegal encodings instead of silently decoding them.

## Interface
- XLEN, 32: datapath width (32 only supported for decode; widths carried generically).
- BUF_DEPTH, 2: output FIFO entries, power of 2, ≥2.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_instr  in  32  instruction word
- rf_raddr1 / rf_raddr2  out  5  register file read addresses (combinational from in_instr)
- rf_rdata1 / rf_rdata2  in  XLEN  asynchronous read data
- wb_we  in  1  write-back write enable
- wb_rd  in  5  write-back destination
- wb_data  in  XLEN  write-back data
- ex_load_valid  in  1  EX holds a valid load
- ex_load_rd  in  5  destination of that load
- out_valid  out  1  FIFO head valid
- out_ready  in  1  EX consumes head
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN  head operands
- out_rd, out_rs1, out_rs2  out  5  head register indices
- out_funct3  out  3  head funct3
- out_ctrl  out  17  [3:0] alu_op, [4] src1_sel (1=PC), [5] src2_sel (1=imm), [6] mem_read, [7] mem_write, [8] reg_write, [10:9] wb_sel (00 ALU, 01 MEM, 10 PC+4), [11] branch, [12] jal, [13] jalr, [14] mul, [15] div, [16] illegal
- hazard_stall  out  1  load-use stall active this cycle

## Operation
- alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- Immediates I/S/B/U/J sign-extended per RV32I; zero for R-type.
- Accept = in_valid && in_ready. in_ready = !full && !hazard_stall && !flush; independent of out_ready (no combinational ready path).
- hazard_stall = in_valid && ex_load_valid && ex_load_rd≠0 && ((uses_rs1 && rs1==ex_load_rd) || (uses_rs2 && rs2==ex_load_rd)). uses_rs1: R, OP-IMM, LOAD, STORE, BRANCH, JALR. uses_rs2: R, STORE, BRANCH.
- Bypass: if wb_we && wb_rd≠0 && wb_rd==rs1, stored rs1_data = wb_data, else rf_rdata1; same for rs2.
- LUI: stored rs1_data = 0, out_rs1 = 0, src1_sel = 0, ADD with imm.
- AUIPC: src1_sel = 1. Other encodings per RV32I.
- Illegal when any of:
  - opcode outside {R, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC};
  - R funct7 ∉ {0000000, 0100000 (funct3 000/101 only)};
  - SLLI funct7≠0; SRLI/SRAI funct7 ∉ {0000000, 0100000};
  - JALR funct3≠0; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3 ≥011.
- Illegal entries are enqueued with ctrl[16]=1 and ctrl[15:6]=0.
- FIFO: push on accept, pop on out_valid && out_ready. Simultaneous push/pop keeps count. Pointers wrap modulo BUF_DEPTH. full = count==BUF_DEPTH.
- Outputs are the head entry. When out_valid=0, out_ctrl=0 (other fields don't-care but deterministic).
- flush: next cycle count=0, pointers=0; instruction offered in the flush cycle is not accepted; flush dominates push and pop.

## Timing
- Reset: count, pointers, all entries 0; out_valid=0, out_ctrl=0, all out_* data 0; in_ready=1 in the first cycle after reset deasserts.
- Latency: accept in cycle N → out_valid in N+1 if FIFO was empty. Throughput 1 instr/cycle with out_ready held high.
- Full FIFO with pop in cycle N: in_ready=0 in N, 1 in N+1.
- hazard_stall clears the cycle ex_load_valid drops; instruction accepted that cycle with current rf/bypass data.
- rst mid-operation discards all entries, same as reset values.

## Configuration
- ID_MEXT_EN defined: funct7=0000001 R-type decodes to mul (funct3 0–3) or div (funct3 4–7), reg_write=1, alu_op=0.
- ID_MEXT_EN undefined: funct7=0000001 is illegal; ctrl[15:14] tied 0.

## Test plan
- ADDI x5,x1,-3 (0xFFD08293), rf_rdata1=10 → next cycle out_valid=1, out_imm=0xFFFFFFFD, rs1_data=10, alu_op=0, src2_sel=1, reg_write=1.
- Bypass: ADD x3,x1,x2 with wb_we=1, wb_rd=1, wb_data=0x55, rf_rdata1=0 → out_rs1_data=0x55. With wb_rd=0 → uses rf_rdata1.
- Load-use: ex_load_valid=1, ex_load_rd=1, SW x1,0(x2) offered → hazard_stall=1, in_ready=0. Drop ex_load_valid → accepted next cycle.
- Backpressure: out_ready=0, offer 3 instructions with BUF_DEPTH=2 → 2 accepted, in_ready=0. Raise out_ready → head order preserved, third accepted one cycle after first pop.
- Flush with FIFO holding 2 and in_valid=1 → next cycle out_valid=0, count=0, offered instruction not accepted.
- Illegal: 0x0000007F and MUL x1,x2,x3 with ID_MEXT_EN undefined → ctrl[16]=1, reg_write=0. With ID_MEXT_EN defined, MUL → mul=1, illegal=0.
